ctrl_decode_pipe: RTL and testbench

//  Parametrised MIPS decode-stage control unit with a registered ID/EX control slice.

---
 rtl/ctrl_decode_pipe_if.sv | 46 ++++
 rtl/ctrl_decode_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if
// Bundles the decode-stage inputs and the registered ID/EX control slice
// of ctrl_decode_pipe into one interface.
//   master : drives instr_d/valid_d/stall/flush, observes the *_e outputs
//            (IF/ID side, hazard unit, testbench)
//   slave  : the decode pipe itself
// Parameters must match the ctrl_decode_pipe instance they are attached to.
interface ctrl_decode_pipe_if #(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 8
);
    logic [31:0]          instr_d;
    logic                 valid_d;
    logic                 stall;
    logic                 flush;

    logic                 ready;
    logic                 valid_e;
    logic [31:0]          instr_e;
    logic                 reg_write_e;
    logic                 mem_to_reg_e;
    logic                 mem_write_e;
    logic                 alu_src_e;
    logic                 reg_dst_e;
    logic                 shift_var_e;
    logic                 jump_e;
    logic                 jr_e;
    logic [2:0]           br_type_e;
    logic [ALUCTRL_W-1:0] alu_ctrl_e;
    logic                 illegal_e;
    logic [CNT_W-1:0]     illegal_cnt;

    modport master (
        output instr_d, valid_d, stall, flush,
        input  ready, valid_e, instr_e, reg_write_e, mem_to_reg_e, mem_write_e,
               alu_src_e, reg_dst_e, shift_var_e, jump_e, jr_e, br_type_e,
               alu_ctrl_e, illegal_e, illegal_cnt
    );

    modport slave (
        input  instr_d, valid_d, stall, flush,
        output ready, valid_e, instr_e, reg_write_e, mem_to_reg_e, mem_write_e,
               alu_src_e, reg_dst_e, shift_var_e, jump_e, jr_e, br_type_e,
               alu_ctrl_e, illegal_e, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
// MIPS decode-stage control unit with a registered ID/EX control slice.
// Decodes the D-stage instruction into main control, ALU op and branch
// type, and holds the result in the E register. Supports stall, flush,
// a post-reset warm-up window of bubbles, and flags/counts illegal
// encodings with a saturating counter.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : ctrl_decode_pipe_if.slave
//            in  : instr_d, valid_d, stall, flush
//            out : ready, valid_e, instr_e, control bits (*_e),
//                  br_type_e, alu_ctrl_e, illegal_e, illegal_cnt
module ctrl_decode_pipe #(
    parameter int WARMUP_CYC = 2,
    parameter int ALUCTRL_W  = 4,
    parameter int CNT_W      = 8,
    parameter int HAS_SHIFTS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_decode_pipe_if.slave bus
);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    // WARMUP_CYC of 0 and 1 both leave WARMUP on the first edge after reset.
    localparam logic [3:0] WARM_LAST = (WARMUP_CYC == 0) ? 4'd0 : 4'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    typedef struct packed {
        logic                 valid;
        logic                 illegal;
        logic                 regWrite;
        logic                 memToReg;
        logic                 memWrite;
        logic                 aluSrc;
        logic                 regDst;
        logic                 shiftVar;
        logic                 jump;
        logic                 jr;
        logic [2:0]           brType;
        logic [ALUCTRL_W-1:0] aluCtrl;
        logic [31:0]          instr;
    } eSlot_t;

    localparam eSlot_t BUBBLE = '0;

    logic [0:0]       state;
    logic [3:0]       warmCnt;
    logic [CNT_W-1:0] illegalCnt;
    eSlot_t           eReg;
    eSlot_t           eNext;
    logic [3:0]       aluOp;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             loadEn;

    assign opcode = bus.instr_d[31:26];
    assign funct  = bus.instr_d[5:0];

    // A decoded instruction is only taken in RUN with neither flush nor stall.
    assign loadEn = (state == ST_RUN) && !bus.flush && !bus.stall;

    // Combinational decode of instr_d. Illegal encodings leave every
    // control bit at its default of 0 and only raise the illegal flag.
    always_comb begin
        eNext       = BUBBLE;
        aluOp       = ALU_ADD;
        eNext.valid = 1'b1;
        eNext.instr = bus.instr_d;
        if (bus.instr_d != 32'd0) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                            eNext.regWrite = 1'b1;
                            eNext.regDst   = 1'b1;
                            case (funct)
                                FN_SUB, FN_SUBU: aluOp = ALU_SUB;
                                FN_AND:          aluOp = ALU_AND;
                                FN_OR:           aluOp = ALU_OR;
                                FN_XOR:          aluOp = ALU_XOR;
                                FN_NOR:          aluOp = ALU_NOR;
                                FN_SLT:          aluOp = ALU_SLT;
                                FN_SLTU:         aluOp = ALU_SLTU;
                                default:         aluOp = ALU_ADD;
                            endcase
                        end
                        FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                            if (HAS_SHIFTS != 0) begin
                                eNext.regWrite = 1'b1;
                                eNext.regDst   = 1'b1;
                                // funct[2] selects the variable form, funct[1:0] the kind.
                                eNext.shiftVar = funct[2];
                                if (!funct[1])     aluOp = ALU_SLL;
                                else if (funct[0]) aluOp = ALU_SRA;
                                else               aluOp = ALU_SRL;
                            end else begin
                                eNext.illegal = 1'b1;
                            end
                        end
                        FN_JR:   eNext.jr      = 1'b1;
                        default: eNext.illegal = 1'b1;
                    endcase
                end
                OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    eNext.regWrite = 1'b1;
                    eNext.aluSrc   = 1'b1;
                    case (opcode)
                        OP_SLTI:  aluOp = ALU_SLT;
                        OP_SLTIU: aluOp = ALU_SLTU;
                        OP_ANDI:  aluOp = ALU_AND;
                        OP_ORI:   aluOp = ALU_OR;
                        OP_XORI:  aluOp = ALU_XOR;
                        OP_LUI:   aluOp = ALU_LUI;
                        default:  aluOp = ALU_ADD;
                    endcase
                end
                OP_LW: begin
                    eNext.regWrite = 1'b1;
                    eNext.memToReg = 1'b1;
                    eNext.aluSrc   = 1'b1;
                end
                OP_SW: begin
                    eNext.memWrite = 1'b1;
                    eNext.aluSrc   = 1'b1;
                end
                OP_BEQ: begin
                    eNext.brType = BR_BEQ;
                    aluOp        = ALU_SUB;
                end
                OP_BNE: begin
                    eNext.brType = BR_BNE;
                    aluOp        = ALU_SUB;
                end
                OP_BLEZ:   eNext.brType = BR_BLEZ;
                OP_BGTZ:   eNext.brType = BR_BGTZ;
                // REGIMM: only rt[0] distinguishes BLTZ from BGEZ.
                OP_REGIMM: eNext.brType = bus.instr_d[16] ? BR_BGEZ : BR_BLTZ;
                OP_J:      eNext.jump   = 1'b1;
                default:   eNext.illegal = 1'b1;
            endcase
        end
        eNext.aluCtrl = ALUCTRL_W'(aluOp);
    end

    // Warm-up FSM: count edges after reset, then stay in RUN until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_WARMUP;
            warmCnt <= 4'd0;
        end else if (state == ST_WARMUP) begin
            if (warmCnt == WARM_LAST) state <= ST_RUN;
            else                      warmCnt <= warmCnt + 4'd1;
        end
    end

    // E register: flush (and warm-up) beat stall; stall holds the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eReg <= BUBBLE;
        end else if ((state == ST_WARMUP) || bus.flush) begin
            eReg <= BUBBLE;
        end else if (!bus.stall) begin
            eReg <= bus.valid_d ? eNext : BUBBLE;
        end
    end

    // Counts only illegal instructions actually loaded into E.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegalCnt <= '0;
        end else if (loadEn && bus.valid_d && eNext.illegal && (illegalCnt != CNT_MAX)) begin
            illegalCnt <= illegalCnt + CNT_W'(1);
        end
    end

    assign bus.ready        = (state == ST_RUN);
    assign bus.valid_e      = eReg.valid;
    assign bus.instr_e      = eReg.instr;
    assign bus.reg_write_e  = eReg.regWrite;
    assign bus.mem_to_reg_e = eReg.memToReg;
    assign bus.mem_write_e  = eReg.memWrite;
    assign bus.alu_src_e    = eReg.aluSrc;
    assign bus.reg_dst_e    = eReg.regDst;
    assign bus.shift_var_e  = eReg.shiftVar;
    assign bus.jump_e       = eReg.jump;
    assign bus.jr_e         = eReg.jr;
    assign bus.br_type_e    = eReg.brType;
    assign bus.alu_ctrl_e   = eReg.aluCtrl;
    assign bus.illegal_e    = eReg.illegal;
    assign bus.illegal_cnt  = illegalCnt;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe
// Drives two decode pipes with identical stimulus:
//   dutA : WARMUP_CYC=2, CNT_W=2, HAS_SHIFTS=1 (main instance, fully checked)
//   dutB : WARMUP_CYC=0, CNT_W=8, HAS_SHIFTS=0 (checked at selected points)
// Expected dutA outputs come from a hand-written vector table and are
// queued when each vector is driven, then popped and compared after the edge.
module tb_ctrl_decode_pipe;

    localparam logic [7:0] C_RW   = 8'h80;
    localparam logic [7:0] C_M2R  = 8'h40;
    localparam logic [7:0] C_MW   = 8'h20;
    localparam logic [7:0] C_ASRC = 8'h10;
    localparam logic [7:0] C_RDST = 8'h08;
    localparam logic [7:0] C_SVAR = 8'h04;
    localparam logic [7:0] C_J    = 8'h02;
    localparam logic [7:0] C_JR   = 8'h01;

    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BNE  = 32'h14220004;
    localparam logic [31:0] I_LUI  = 32'h3C011234;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SLLV = 32'h00431004;
    localparam logic [31:0] I_BAD  = 32'hFC000000;

    typedef struct {
        logic        ready;
        logic        vE;
        logic        ill;
        logic [7:0]  ctl;
        logic [2:0]  br;
        logic [3:0]  alu;
        logic [31:0] instrE;
        logic [1:0]  cnt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        stall;
        logic        flush;
        exp_t        exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    exp_t expQ[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ctrl_decode_pipe_if #(.ALUCTRL_W(4), .CNT_W(2)) busA ();
    ctrl_decode_pipe_if #(.ALUCTRL_W(4), .CNT_W(8)) busB ();

    ctrl_decode_pipe #(.WARMUP_CYC(2), .ALUCTRL_W(4), .CNT_W(2), .HAS_SHIFTS(1)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );

    ctrl_decode_pipe #(.WARMUP_CYC(0), .ALUCTRL_W(4), .CNT_W(8), .HAS_SHIFTS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    function automatic vec_t mk(input logic [31:0] i, input logic v, input logic s, input logic f,
                                input logic rdy, input logic vE, input logic ill, input logic [7:0] ctl,
                                input logic [2:0] br, input logic [3:0] alu, input logic [31:0] ie,
                                input logic [1:0] cnt);
        vec_t r;
        r.instr = i; r.valid = v; r.stall = s; r.flush = f;
        r.exp.ready = rdy; r.exp.vE = vE; r.exp.ill = ill; r.exp.ctl = ctl;
        r.exp.br = br; r.exp.alu = alu; r.exp.instrE = ie; r.exp.cnt = cnt;
        return r;
    endfunction

    // Bubble expectation with a given ready/count.
    function automatic vec_t bub(input logic [31:0] i, input logic v, input logic s, input logic f,
                                 input logic rdy, input logic [1:0] cnt);
        return mk(i, v, s, f, rdy, 1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 32'd0, cnt);
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        busA.instr_d = v.instr; busA.valid_d = v.valid; busA.stall = v.stall; busA.flush = v.flush;
        busB.instr_d = v.instr; busB.valid_d = v.valid; busB.stall = v.stall; busB.flush = v.flush;
        expQ.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (expQ.size() == 0) begin
            cmp("scoreboard_empty", idx, 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        cmp("ready",        idx, 32'(busA.ready),        32'(e.ready));
        cmp("valid_e",      idx, 32'(busA.valid_e),      32'(e.vE));
        cmp("illegal_e",    idx, 32'(busA.illegal_e),    32'(e.ill));
        cmp("reg_write_e",  idx, 32'(busA.reg_write_e),  32'(e.ctl[7]));
        cmp("mem_to_reg_e", idx, 32'(busA.mem_to_reg_e), 32'(e.ctl[6]));
        cmp("mem_write_e",  idx, 32'(busA.mem_write_e),  32'(e.ctl[5]));
        cmp("alu_src_e",    idx, 32'(busA.alu_src_e),    32'(e.ctl[4]));
        cmp("reg_dst_e",    idx, 32'(busA.reg_dst_e),    32'(e.ctl[3]));
        cmp("shift_var_e",  idx, 32'(busA.shift_var_e),  32'(e.ctl[2]));
        cmp("jump_e",       idx, 32'(busA.jump_e),       32'(e.ctl[1]));
        cmp("jr_e",         idx, 32'(busA.jr_e),         32'(e.ctl[0]));
        cmp("br_type_e",    idx, 32'(busA.br_type_e),    32'(e.br));
        cmp("alu_ctrl_e",   idx, 32'(busA.alu_ctrl_e),   32'(e.alu));
        cmp("instr_e",      idx, busA.instr_e,           e.instrE);
        cmp("illegal_cnt",  idx, 32'(busA.illegal_cnt),  32'(e.cnt));
    endtask

    // Watchdog: the stimulus is purely clock-paced, this only guards a broken build.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int step;
        busA.instr_d = '0; busA.valid_d = 1'b0; busA.stall = 1'b0; busA.flush = 1'b0;
        busB.instr_d = '0; busB.valid_d = 1'b0; busB.stall = 1'b0; busB.flush = 1'b0;
        step = 0;

        // Reset with an instruction already presented: slot must stay a bubble.
        rst_n = 1'b0;
        applyStimulus(bub(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        checkOutput(step++);
        cmp("B_ready_reset", step, 32'(busB.ready), 32'd0);
        rst_n = 1'b1;

        // Warm-up (two bubbles), full decode coverage, stall/flush, illegal saturation.
        tbl.push_back(bub(I_ADDI, 1, 0, 0, 0, 0));
        tbl.push_back(bub(I_ADDI, 1, 0, 0, 1, 0));
        tbl.push_back(mk(I_ADDI,       1, 0, 0, 1, 1, 0, C_RW | C_ASRC,         0, 0,  I_ADDI,       0));
        tbl.push_back(mk(I_LW,         1, 0, 0, 1, 1, 0, C_RW | C_M2R | C_ASRC, 0, 0,  I_LW,         0));
        tbl.push_back(mk(I_SW,         1, 0, 0, 1, 1, 0, C_MW | C_ASRC,         0, 0,  I_SW,         0));
        tbl.push_back(mk(32'h04210004, 1, 0, 0, 1, 1, 0, 8'h00,                 6, 0,  32'h04210004, 0));
        tbl.push_back(mk(32'h04200004, 1, 0, 0, 1, 1, 0, 8'h00,                 5, 0,  32'h04200004, 0));
        tbl.push_back(mk(I_BNE,        1, 0, 0, 1, 1, 0, 8'h00,                 2, 1,  I_BNE,        0));
        tbl.push_back(mk(32'h10220004, 1, 0, 0, 1, 1, 0, 8'h00,                 1, 1,  32'h10220004, 0));
        tbl.push_back(mk(32'h18200004, 1, 0, 0, 1, 1, 0, 8'h00,                 3, 0,  32'h18200004, 0));
        tbl.push_back(mk(32'h1C200004, 1, 0, 0, 1, 1, 0, 8'h00,                 4, 0,  32'h1C200004, 0));
        tbl.push_back(mk(32'h08000010, 1, 0, 0, 1, 1, 0, C_J,                   0, 0,  32'h08000010, 0));
        tbl.push_back(mk(32'h03E00008, 1, 0, 0, 1, 1, 0, C_JR,                  0, 0,  32'h03E00008, 0));
        tbl.push_back(mk(I_LUI,        1, 0, 0, 1, 1, 0, C_RW | C_ASRC,         0, 11, I_LUI,        0));
        tbl.push_back(mk(32'h2C220005, 1, 0, 0, 1, 1, 0, C_RW | C_ASRC,         0, 7,  32'h2C220005, 0));
        tbl.push_back(mk(I_ADD,        1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 0,  I_ADD,        0));
        tbl.push_back(mk(32'h00221822, 1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 1,  32'h00221822, 0));
        tbl.push_back(mk(32'h00221826, 1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 4,  32'h00221826, 0));
        tbl.push_back(mk(32'h00221827, 1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 5,  32'h00221827, 0));
        tbl.push_back(mk(32'h0022182A, 1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 6,  32'h0022182A, 0));
        tbl.push_back(mk(32'h00021903, 1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 10, 32'h00021903, 0));
        tbl.push_back(mk(32'h00431006, 1, 0, 0, 1, 1, 0, C_RW | C_RDST | C_SVAR, 0, 9, 32'h00431006, 0));
        tbl.push_back(mk(I_SLLV,       1, 0, 0, 1, 1, 0, C_RW | C_RDST | C_SVAR, 0, 8, I_SLLV,       0));
        tbl.push_back(mk(32'h00000000, 1, 0, 0, 1, 1, 0, 8'h00,                 0, 0,  32'h00000000, 0));
        tbl.push_back(bub(I_ADD, 0, 0, 0, 1, 0));
        tbl.push_back(mk(I_ADDI,       1, 0, 0, 1, 1, 0, C_RW | C_ASRC,         0, 0,  I_ADDI,       0));
        tbl.push_back(mk(I_LW,         1, 1, 0, 1, 1, 0, C_RW | C_ASRC,         0, 0,  I_ADDI,       0));
        tbl.push_back(mk(I_SW,         1, 1, 0, 1, 1, 0, C_RW | C_ASRC,         0, 0,  I_ADDI,       0));
        tbl.push_back(mk(I_BAD,        1, 1, 0, 1, 1, 0, C_RW | C_ASRC,         0, 0,  I_ADDI,       0));
        tbl.push_back(bub(I_BNE, 1, 1, 1, 1, 0));
        tbl.push_back(bub(I_BAD, 1, 0, 1, 1, 0));
        tbl.push_back(mk(I_LUI,        1, 0, 0, 1, 1, 0, C_RW | C_ASRC,         0, 11, I_LUI,        0));
        tbl.push_back(mk(I_BAD,        1, 0, 0, 1, 1, 1, 8'h00,                 0, 0,  I_BAD,        1));
        tbl.push_back(mk(I_BAD,        1, 0, 0, 1, 1, 1, 8'h00,                 0, 0,  I_BAD,        2));
        tbl.push_back(mk(I_BAD,        1, 0, 0, 1, 1, 1, 8'h00,                 0, 0,  I_BAD,        3));
        tbl.push_back(mk(I_BAD,        1, 0, 0, 1, 1, 1, 8'h00,                 0, 0,  I_BAD,        3));
        tbl.push_back(mk(32'h00221801, 1, 0, 0, 1, 1, 1, 8'h00,                 0, 0,  32'h00221801, 3));
        tbl.push_back(mk(I_ADD,        1, 0, 0, 1, 1, 0, C_RW | C_RDST,         0, 0,  I_ADD,        3));

        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            checkOutput(step++);
        end

        // Reset mid-operation while stall is high: overrides hold, clears the counter.
        rst_n = 1'b0;
        applyStimulus(bub(I_ADD, 1, 1, 0, 0, 0));
        checkOutput(step++);

        // Release: dutA needs two warm-up edges, dutB (no warm-up) is ready after one.
        rst_n = 1'b1;
        applyStimulus(bub(I_ADD, 1, 0, 0, 0, 0));
        checkOutput(step++);
        cmp("B_ready_edge1", step, 32'(busB.ready),   32'd1);
        cmp("B_valid_edge1", step, 32'(busB.valid_e), 32'd0);
        applyStimulus(bub(I_ADD, 1, 0, 0, 1, 0));
        checkOutput(step++);
        cmp("B_valid_edge2",     step, 32'(busB.valid_e),     32'd1);
        cmp("B_reg_write_edge2", step, 32'(busB.reg_write_e), 32'd1);

        // SLLV: legal shift on dutA, illegal on the no-shift dutB.
        applyStimulus(mk(I_SLLV, 1, 0, 0, 1, 1, 0, C_RW | C_RDST | C_SVAR, 0, 8, I_SLLV, 0));
        checkOutput(step++);
        cmp("B_sllv_illegal",   step, 32'(busB.illegal_e),   32'd1);
        cmp("B_sllv_valid",     step, 32'(busB.valid_e),     32'd1);
        cmp("B_sllv_reg_write", step, 32'(busB.reg_write_e), 32'd0);
        cmp("B_sllv_reg_dst",   step, 32'(busB.reg_dst_e),   32'd0);
        cmp("B_sllv_cnt",       step, 32'(busB.illegal_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
